reset_sequencer: RTL and testbench

- Board-level reset controller for the iCE40 design. It gates reset release on PLL lock, holds all domains in reset for a minimum time, and then releases NUM_DOMAINS synchronous domain resets one at a time in index order.
- It also re-asserts all domain resets on PLL lock loss or a software request, and reports the cause of the last reset.
- It sits between the external reset/PLL and the per-domain logic; all outputs are synchronous to clk.

---
 rtl/reset_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_reset_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// Shared encodings for the board reset sequencer: FSM states and reset-cause codes.
package reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;

  // Lock loss outranks a watchdog expiry, which outranks a software request.
  function automatic logic [1:0] abort_cause(input logic lock_lost,
                                             input logic wdog_expired);
    if (lock_lost) begin
      return CAUSE_LOCK;
    end else if (wdog_expired) begin
      return CAUSE_WDOG;
    end else begin
      return CAUSE_SW;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer with asynchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: holds all domains until the PLL is stably locked, then releases
// them one by one. Optional watchdog (port wdog_kick) is enabled by RESET_SEQUENCER_WDOG_EN.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDOG_CYCLES    = 1024
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
`ifdef RESET_SEQUENCER_WDOG_EN
  input  logic                   wdog_kick,
`endif
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [1:0]             reset_cause
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;
  logic                   locked_s;
  logic                   wdog_expired;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .clear (reset_in),
    .d     (pll_locked),
    .q     (locked_s)
  );

`ifdef RESET_SEQUENCER_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);

  logic [WD_W-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d       = wdog_q;
    wdog_expired = 1'b0;
    if (state_q != ST_RUN || wdog_kick) begin
      wdog_d = '0;
    end else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
      wdog_expired = 1'b1;
      wdog_d       = '0;
    end else begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog_cfg;

  assign unused_wdog_cfg = (WDOG_CYCLES > 1);
  assign wdog_expired    = 1'b0;
`endif

  // Next-state and registered-output logic; an abort always overrides stagger progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;

    case (state_q)
      ST_ASSERT: begin
        rst_d   = '1;
        ready_d = 1'b0;
        if (!locked_s || sw_reset_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d  = ST_RELEASE;
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          idx_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (!locked_s || sw_reset_req || wdog_expired) begin
          state_d = ST_ASSERT;
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          cause_d = abort_cause(!locked_s, wdog_expired);
        end else if (state_q == ST_RELEASE) begin
          if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
            cnt_d = '0;
            if (int'(idx_q) == NUM_DOMAINS - 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              for (int i = 1; i < NUM_DOMAINS; i++) begin
                if (i == int'(idx_q) + 1) begin
                  rst_d[i] = 1'b0;
                end
              end
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_ASSERT;
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign rst_out     = rst_q;
  assign ready       = ready_q;
  assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer; the watchdog scenario runs when RESET_SEQUENCER_WDOG_EN is defined.
module tb_reset_sequencer;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset_in;
  logic         pll_locked;
  logic         sw_reset_req;
  logic         wdog_kick;
  logic [N-1:0] rst_out;
  logic         ready;
  logic [1:0]   reset_cause;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_DOMAINS    (N),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (4),
    .WDOG_CYCLES    (8)
  ) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
`ifdef RESET_SEQUENCER_WDOG_EN
    .wdog_kick    (wdog_kick),
`endif
    .rst_out      (rst_out),
    .ready        (ready),
    .reset_cause  (reset_cause)
  );

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic locked, input logic sw, input int n);
    pll_locked   = locked;
    sw_reset_req = sw;
    tick(n);
  endtask

  initial begin
    reset_in     = 1'b1;
    pll_locked   = 1'b1;
    sw_reset_req = 1'b0;
    wdog_kick    = 1'b0;

    tick(3);
    check_output("por_rst", rst_out, 3'b111);
    check_output("por_ready", ready, 0);
    check_output("por_cause", reset_cause, 0);

    // Nominal power-up; the next edge after release is edge 1.
    reset_in = 1'b0;
    apply_stimulus(1'b1, 1'b0, 17);
    check_output("nom_e17", rst_out, 3'b111);
    tick(1);
    check_output("nom_e18", rst_out, 3'b110);
    tick(3);
    check_output("nom_e21", rst_out, 3'b110);
    tick(1);
    check_output("nom_e22", rst_out, 3'b100);
    tick(4);
    check_output("nom_e26", rst_out, 3'b000);
    tick(3);
    check_output("nom_e29_ready", ready, 0);
    tick(1);
    check_output("nom_e30_ready", ready, 1);
    check_output("nom_cause", reset_cause, 0);

    // Lock loss in RUN: two sync edges, then the abort edge.
    apply_stimulus(1'b0, 1'b0, 2);
    check_output("lock_pre_rst", rst_out, 3'b000);
    tick(1);
    check_output("lock_rst", rst_out, 3'b111);
    check_output("lock_ready", ready, 0);
    check_output("lock_cause", reset_cause, 1);
    apply_stimulus(1'b1, 1'b0, 17);
    check_output("relock_e17", rst_out, 3'b111);
    tick(1);
    check_output("relock_e18", rst_out, 3'b110);
    tick(12);
    check_output("relock_ready", ready, 1);
    check_output("relock_cause", reset_cause, 1);

    // Asynchronous reset from RUN clears the cause immediately.
    reset_in = 1'b1;
    #1;
    check_output("arst_rst", rst_out, 3'b111);
    check_output("arst_cause", reset_cause, 0);
    reset_in = 1'b0;

    // One-cycle lock glitch when cnt reaches 10 (after edge 12): release moves to edge 31.
    apply_stimulus(1'b1, 1'b0, 12);
    apply_stimulus(1'b0, 1'b0, 1);
    apply_stimulus(1'b1, 1'b0, 17);
    check_output("glitch_e30", rst_out, 3'b111);
    tick(1);
    check_output("glitch_e31", rst_out, 3'b110);
    check_output("glitch_cause", reset_cause, 0);

    // Software request for 5 cycles while rst_out=110.
    apply_stimulus(1'b1, 1'b1, 1);
    check_output("sw_rst", rst_out, 3'b111);
    check_output("sw_cause", reset_cause, 2);
    apply_stimulus(1'b1, 1'b1, 4);
    check_output("sw_hold_rst", rst_out, 3'b111);
    apply_stimulus(1'b1, 1'b0, 15);
    check_output("sw_after15", rst_out, 3'b111);
    tick(1);
    check_output("sw_after16", rst_out, 3'b110);
    check_output("sw_cause_kept", reset_cause, 2);

    // Reset pulse mid-RELEASE.
    tick(2);
    reset_in = 1'b1;
    #1;
    check_output("mid_arst_rst", rst_out, 3'b111);
    check_output("mid_arst_cause", reset_cause, 0);
    tick(1);
    reset_in = 1'b0;
    tick(30);
    check_output("mid_arst_ready", ready, 1);
    check_output("mid_arst_run_rst", rst_out, 3'b000);

    // Lock loss and software request seen in the same cycle.
    apply_stimulus(1'b0, 1'b0, 2);
    apply_stimulus(1'b0, 1'b1, 1);
    check_output("both_rst", rst_out, 3'b111);
    check_output("both_cause", reset_cause, 1);
    apply_stimulus(1'b1, 1'b0, 29);
    check_output("both_relock_e29", ready, 0);
    tick(1);
    check_output("both_relock_e30", ready, 1);
    check_output("both_relock_rst", rst_out, 3'b000);

`ifdef RESET_SEQUENCER_WDOG_EN
    for (int k = 0; k < 4; k++) begin
      tick(4);
      wdog_kick = 1'b1;
      tick(1);
      wdog_kick = 1'b0;
    end
    check_output("wdog_kicked_ready", ready, 1);
    check_output("wdog_kicked_rst", rst_out, 3'b000);
    tick(7);
    check_output("wdog_7_ready", ready, 1);
    tick(1);
    check_output("wdog_8_rst", rst_out, 3'b111);
    check_output("wdog_8_cause", reset_cause, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
